// File: rtl/assign_style_ff_pair.sv
// Purpose: two D-register pipelines from one input (true shift register vs. collapsed in-order update) plus a disagreement monitor.
// Latency: q_nonblocking DEPTH edges, q_blocking 1 edge; mismatch is combinational from the two output registers.
// Backpressure: none; en=0 freezes both pipelines while the mismatch counter keeps sampling.
module assign_style_ff_pair #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q_nonblocking,
  output logic [WIDTH-1:0] q_blocking,
  output logic             mismatch,
  output logic [CNT_W-1:0] mismatch_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q, cnt_d;

  genvar i;
  generate
    // True shift register: each stage loads its predecessor's pre-edge value.
    for (i = 0; i < DEPTH; i++) begin : g_nb
      logic [WIDTH-1:0] st_q, st_d;
      if (i == 0) begin : g_src
        assign st_d = en ? d : st_q;
      end else begin : g_src
        assign st_d = en ? g_nb[i-1].st_q : st_q;
      end
      // One stage of the simultaneous-update pipeline.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st_q <= '0;
        else        st_q <= st_d;
      end
    end

    // Collapsed pipeline: each stage sees the already-updated previous stage,
    // so the chain is taken from the next-state values, not the registers.
    for (i = 0; i < DEPTH; i++) begin : g_bl
      logic [WIDTH-1:0] st_q, st_d;
      if (i == 0) begin : g_src
        assign st_d = en ? d : st_q;
      end else begin : g_src
        assign st_d = en ? g_bl[i-1].st_d : st_q;
      end
      // One stage of the in-order-update pipeline.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st_q <= '0;
        else        st_q <= st_d;
      end
    end
  endgenerate

  assign q_nonblocking = g_nb[DEPTH-1].st_q;
  assign q_blocking    = g_bl[DEPTH-1].st_q;
  assign mismatch      = (q_blocking != q_nonblocking);

  // Saturating increment on every edge where the outputs disagree, regardless of en.
  always_comb begin
    cnt_d = cnt_q;
    if (mismatch && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
  end

  // Mismatch counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign mismatch_cnt = cnt_q;

endmodule

// File: tb/tb_assign_style_ff_pair.sv
`timescale 1ns/1ps
module tb_assign_style_ff_pair;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // u1: DEPTH=1 WIDTH=1
  logic       en1, d1, nb1, bl1, mm1;
  logic [7:0] cnt1;
  // u3: DEPTH=3 WIDTH=8
  logic       en3, mm3;
  logic [7:0] d3, nb3, bl3, cnt3;
  // u2: DEPTH=2 WIDTH=8 CNT_W=2
  logic       en2, mm2;
  logic [7:0] d2, nb2, bl2;
  logic [1:0] cnt2;

  assign_style_ff_pair #(.WIDTH(1), .DEPTH(1), .CNT_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .d(d1),
    .q_nonblocking(nb1), .q_blocking(bl1), .mismatch(mm1), .mismatch_cnt(cnt1));

  assign_style_ff_pair #(.WIDTH(8), .DEPTH(3), .CNT_W(8)) u3 (
    .clk(clk), .rst_n(rst_n), .en(en3), .d(d3),
    .q_nonblocking(nb3), .q_blocking(bl3), .mismatch(mm3), .mismatch_cnt(cnt3));

  assign_style_ff_pair #(.WIDTH(8), .DEPTH(2), .CNT_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .en(en2), .d(d2),
    .q_nonblocking(nb2), .q_blocking(bl2), .mismatch(mm2), .mismatch_cnt(cnt2));

  typedef struct {
    bit         sel;   // 0 -> u3, 1 -> u2
    logic       en;
    logic [7:0] d;
    logic [7:0] nb;
    logic [7:0] bl;
    logic       mm;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[18];
  vec_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic vec_t mk(bit sel, logic en, logic [7:0] d, logic [7:0] nb,
                              logic [7:0] bl, logic mm, logic [7:0] cnt);
    vec_t v;
    v.sel = sel; v.en = en; v.d = d; v.nb = nb; v.bl = bl; v.mm = mm; v.cnt = cnt;
    return v;
  endfunction

  task automatic run_vec(input int idx);
    vec_t v, e;
    v = tbl[idx];
    @(negedge clk);
    if (v.sel == 1'b0) begin en3 = v.en; d3 = v.d; end
    else               begin en2 = v.en; d2 = v.d; end
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (e.sel == 1'b0) begin
      check($sformatf("v%0d_u3_nb", idx),  32'(nb3),  32'(e.nb));
      check($sformatf("v%0d_u3_bl", idx),  32'(bl3),  32'(e.bl));
      check($sformatf("v%0d_u3_mm", idx),  32'(mm3),  32'(e.mm));
      check($sformatf("v%0d_u3_cnt", idx), 32'(cnt3), 32'(e.cnt));
    end else begin
      check($sformatf("v%0d_u2_nb", idx),  32'(nb2),  32'(e.nb));
      check($sformatf("v%0d_u2_bl", idx),  32'(bl2),  32'(e.bl));
      check($sformatf("v%0d_u2_mm", idx),  32'(mm2),  32'(e.mm));
      check($sformatf("v%0d_u2_cnt", idx), 32'(cnt2), 32'(e.cnt));
    end
  endtask

  initial begin
    // DEPTH=3 pipeline: fill, hold with en=0, drain to agreement, diverge again.
    tbl[0]  = mk(0, 1, 8'h11, 8'h00, 8'h11, 1, 8'd0);
    tbl[1]  = mk(0, 1, 8'h22, 8'h00, 8'h22, 1, 8'd1);
    tbl[2]  = mk(0, 1, 8'h33, 8'h11, 8'h33, 1, 8'd2);
    tbl[3]  = mk(0, 1, 8'h44, 8'h22, 8'h44, 1, 8'd3);
    tbl[4]  = mk(0, 0, 8'h55, 8'h22, 8'h44, 1, 8'd4);
    tbl[5]  = mk(0, 0, 8'hAA, 8'h22, 8'h44, 1, 8'd5);
    tbl[6]  = mk(0, 0, 8'h55, 8'h22, 8'h44, 1, 8'd6);
    tbl[7]  = mk(0, 1, 8'h44, 8'h33, 8'h44, 1, 8'd7);
    tbl[8]  = mk(0, 1, 8'h44, 8'h44, 8'h44, 0, 8'd8);
    tbl[9]  = mk(0, 1, 8'h44, 8'h44, 8'h44, 0, 8'd8);
    tbl[10] = mk(0, 1, 8'h00, 8'h44, 8'h00, 1, 8'd8);
    tbl[11] = mk(0, 1, 8'h00, 8'h44, 8'h00, 1, 8'd9);
    // CNT_W=2 DEPTH=2 with changing d: counter saturates at 3.
    tbl[12] = mk(1, 1, 8'h01, 8'h00, 8'h01, 1, 8'd0);
    tbl[13] = mk(1, 1, 8'h02, 8'h01, 8'h02, 1, 8'd1);
    tbl[14] = mk(1, 1, 8'h03, 8'h02, 8'h03, 1, 8'd2);
    tbl[15] = mk(1, 1, 8'h04, 8'h03, 8'h04, 1, 8'd3);
    tbl[16] = mk(1, 1, 8'h05, 8'h04, 8'h05, 1, 8'd3);
    tbl[17] = mk(1, 1, 8'h06, 8'h05, 8'h06, 1, 8'd3);

    rst_n = 1'b0;
    en1 = 1'b1; d1 = 1'b0;
    en3 = 1'b1; d3 = 8'h00;
    en2 = 1'b1; d2 = 8'h00;

    // Reset state of all instances.
    #0.5;
    check("rst_u1_nb", 32'(nb1), 0);
    check("rst_u1_bl", 32'(bl1), 0);
    check("rst_u3_nb", 32'(nb3), 0);
    check("rst_u3_bl", 32'(bl3), 0);
    check("rst_u3_mm", 32'(mm3), 0);
    check("rst_u3_cnt", 32'(cnt3), 0);
    check("rst_u2_cnt", 32'(cnt2), 0);
    #0.5 rst_n = 1'b1;                       // t=1

    // DEPTH=1: both outputs follow d one edge later, never disagree.
    #5;  check("d1_t6_nb", 32'(nb1), 0);  check("d1_t6_bl", 32'(bl1), 0);   // t=6
    #6;  d1 = 1'b1;                                                         // t=12
    #2;  check("d1_t14_nb", 32'(nb1), 0); check("d1_t14_bl", 32'(bl1), 0);  // t=14
    #2;  check("d1_t16_nb", 32'(nb1), 1); check("d1_t16_bl", 32'(bl1), 1);  // t=16
    #6;  d1 = 1'b0;                                                         // t=22
    #4;  check("d1_t26_nb", 32'(nb1), 0); check("d1_t26_bl", 32'(bl1), 0);  // t=26
    check("d1_t26_mm", 32'(mm1), 0);
    #6;  d1 = 1'b1;                                                         // t=32
    #4;  check("d1_t36_nb", 32'(nb1), 1); check("d1_t36_bl", 32'(bl1), 1);  // t=36
    check("d1_t36_mm", 32'(mm1), 0);
    check("d1_t36_cnt", 32'(cnt1), 0);

    for (int i = 0; i < 12; i++) run_vec(i);

    // Mid-cycle asynchronous reset with u3 holding non-zero data.
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_u3_nb", 32'(nb3), 0);
    check("arst_u3_bl", 32'(bl3), 0);
    check("arst_u3_mm", 32'(mm3), 0);
    check("arst_u3_cnt", 32'(cnt3), 0);
    check("arst_u1_nb", 32'(nb1), 0);
    @(negedge clk);
    en3 = 1'b1; d3 = 8'h77;
    #1 rst_n = 1'b1;
    #2;
    check("rel_pre_u3_bl", 32'(bl3), 0);
    check("rel_pre_u3_nb", 32'(nb3), 0);
    @(posedge clk); #1;
    check("rel_e1_u3_bl", 32'(bl3), 32'h77);
    check("rel_e1_u3_nb", 32'(nb3), 0);
    check("rel_e1_u3_mm", 32'(mm3), 1);
    check("rel_e1_u3_cnt", 32'(cnt3), 0);
    @(posedge clk); #1;
    check("rel_e2_u3_nb", 32'(nb3), 0);
    check("rel_e2_u3_cnt", 32'(cnt3), 1);
    @(posedge clk); #1;
    check("rel_e3_u3_nb", 32'(nb3), 32'h77);
    check("rel_e3_u3_cnt", 32'(cnt3), 2);
    check("rel_e3_u2_cnt", 32'(cnt2), 0);

    for (int i = 12; i < 18; i++) run_vec(i);

    check("sb_empty", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/assign_style_ff_pair.md
Name: assign_style_ff_pair

Overview:
Side-by-side pair of D-register pipelines fed from one input.
- `q_nonblocking`: a true DEPTH-stage shift register.
- `q_blocking`: the collapsed single-latency register produced by in-order (blocking-style) stage updates.

The block is a reference/teaching element and a mismatch monitor: it flags and counts cycles where the two styles disagree. With DEPTH=1 both outputs are identical and behave as plain D flip-flops.

Parameters:
- WIDTH, 1, data width of `d` and both outputs.
- DEPTH, 1, number of register stages (≥1).
- CNT_W, 8, width of the saturating mismatch counter.

Ports:
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous active-low reset.
- `en`  input  1  stage update enable; hold all state when 0.
- `d`  input  WIDTH  data input, sampled on rising `clk` when `en`=1.
- `q_nonblocking`  output  WIDTH  last stage of the true DEPTH-stage shift register.
- `q_blocking`  output  WIDTH  last stage of the collapsed pipeline.
- `mismatch`  output  1  combinational: `q_blocking != q_nonblocking`.
- `mismatch_cnt`  output  CNT_W  saturating count of rising edges on which `mismatch` was 1.

Behaviour:
- Reset, asynchronous, `rst_n`=0: all stages of both pipelines clear to 0, so `q_nonblocking`=0, `q_blocking`=0, `mismatch`=0, `mismatch_cnt`=0. Takes effect immediately, independent of `clk`/`en`; reset mid-operation discards all in-flight data.
- Non-blocking pipeline, rising edge with `en`=1: all stages update simultaneously from pre-edge values: `stage[0]`←`d`, `stage[i]`←`stage[i-1]`. Latency = DEPTH edges.
- Blocking pipeline, rising edge with `en`=1: stages update in index order, each seeing the already-updated previous stage. Every stage equals `d` after the edge, so latency = 1 edge regardless of DEPTH.
- `en`=0: neither pipeline changes; `mismatch_cnt` still samples `mismatch`.
- `d` changes between edges have no effect until the next rising edge; no output changes except on `clk` rising or `rst_n` falling.
- DEPTH=1: outputs identical every cycle; `mismatch` is constantly 0.
- `mismatch` is purely combinational from the two output registers (no extra latency).
- `mismatch_cnt`: on each rising edge out of reset, if `mismatch`=1 (pre-edge value), increment; saturate at 2^CNT_W−1, no wrap.
- Release of `rst_n` coincident with a clock edge: that edge is ignored; the first capture is on the following edge.
- Implement the two pipelines as separate register arrays with generate loops over DEPTH; no shared state.

Test Plan:
- DEPTH=1, WIDTH=1, 10 ns clock starting low (edges at 5, 15, 25, 35 ns), `en`=1, `rst_n` high after 1 ns. Drive `d`=0, then 1 at 12 ns, 0 at 22 ns, 1 at 32 ns. Required: both outputs 0 until 15 ns, 1 at 15 ns, 0 at 25 ns, 1 at 35 ns; `mismatch`=0 throughout; `mismatch_cnt`=0.
- DEPTH=3, WIDTH=8: apply 0x11, 0x22, 0x33, 0x44 on consecutive edges. Required after each edge:
  - `q_blocking` = 0x11, 0x22, 0x33, 0x44.
  - `q_nonblocking` = 0x00, 0x00, 0x11, 0x22.
  - `mismatch`=1 while they differ; `mismatch_cnt` increments per edge.
- `en`=0 for 3 edges with `d` toggling: both outputs hold their values; `mismatch_cnt` continues counting if `mismatch`=1.
- Assert `rst_n`=0 mid-cycle (not on an edge) with non-zero pipelines: all outputs 0 immediately. Release: the first capture occurs on the next edge.
- CNT_W=2, DEPTH=2, continuously changing `d` for 6 edges: `mismatch_cnt` saturates at 3 and holds.
